// File: rtl/word_packer_if.sv
// rtl/word_packer_if.sv - word stream in, packed beat out, bundled for word_packer
// Purpose: groups the input word handshake, the flush request and the packed beat
//   handshake of word_packer into one bundle.
// Signals:
//   in_ready/in_valid/in_bits  32-bit word queue handshake (in_ready driven by packer)
//   flush                      single-cycle request to emit the partial beat
//   out_ready/out_valid        packed beat handshake (out_valid driven by packer)
//   out_bits/out_keep          packed beat, word k at bits[k*IN_W +: IN_W], keep bit k
// Modports: slave = the packer itself, master = the word source / beat sink side.
interface word_packer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
);
  logic                  in_ready;
  logic                  in_valid;
  logic [IN_W-1:0]       in_bits;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [IN_W*RATIO-1:0] out_bits;
  logic [RATIO-1:0]      out_keep;

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_bits,
    input  flush,
    input  out_ready,
    output out_valid,
    output out_bits,
    output out_keep
  );

  modport master (
    input  in_ready,
    output in_valid,
    output in_bits,
    output flush,
    output out_ready,
    input  out_valid,
    input  out_bits,
    input  out_keep
  );
endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs RATIO consecutive words into one wide beat
// Purpose: consumes 32-bit words, collects RATIO of them into lanes of a single
//   output register and presents the beat with a per-word keep mask. A flush
//   closes a partial beat early; unwritten lanes read as zero. The beat is held
//   until the sink accepts it.
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   io        word_packer_if.slave (word in, flush, packed beat out)
//   io_beats  16-bit emitted-beat count, present only with WORD_PACKER_CNT_EN
// Optional feature macro: WORD_PACKER_CNT_EN
module word_packer #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
) (
  input  logic          clock,
  input  logic          reset,
  word_packer_if.slave  io
`ifdef WORD_PACKER_CNT_EN
  ,
  output logic [15:0]   io_beats
`endif
);

  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                     state, state_n;
  logic [RATIO-1:0][IN_W-1:0] lanes, lanes_n;
  logic [RATIO-1:0]           keep, keep_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic                       in_acc;
  logic                       out_acc;

  // While holding, a word may only enter when the held beat leaves in the same
  // cycle, so back-to-back beats stream without a bubble.
  assign io.in_ready  = (state == FILL) | io.out_ready;
  assign io.out_valid = (state == HOLD);
  assign io.out_bits  = lanes;
  assign io.out_keep  = keep;

  assign in_acc  = io.in_valid & io.in_ready;
  assign out_acc = io.out_valid & io.out_ready;

  always_comb begin
    state_n = state;
    lanes_n = lanes;
    keep_n  = keep;
    cnt_n   = cnt;
    case (state)
      FILL: begin
        if (in_acc) begin
          lanes_n[cnt] = io.in_bits;
          keep_n[cnt]  = 1'b1;
          if (cnt == CNT_LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        // A flush with nothing collected and nothing arriving is dropped so
        // that an empty beat is never emitted.
        if (io.flush && ((cnt != '0) || in_acc)) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        // Flush is ignored here: the held beat is already closed.
        if (out_acc) begin
          state_n = FILL;
          lanes_n = '0;
          keep_n  = '0;
          cnt_n   = '0;
          if (in_acc) begin
            lanes_n[0] = io.in_bits;
            keep_n[0]  = 1'b1;
            cnt_n      = CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      lanes <= '0;
      keep  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      lanes <= lanes_n;
      keep  <= keep_n;
      cnt   <= cnt_n;
    end
  end

`ifdef WORD_PACKER_CNT_EN
  // Counts full and partial beats alike; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_beats <= '0;
    end else if (out_acc) begin
      io_beats <= io_beats + 16'd1;
    end
  end
`endif

endmodule
